// File: rtl/spi_master_irq_ctrl.sv
// spi_master_irq_ctrl
//
// Interrupt front-end for an SPI master. The master's two event lines
// (bit0 = TX-buffer level, bit1 = end-of-transfer) are edge-detected and
// turned into sticky pending flags and per-event saturating counters. Enabled
// events are coalesced (count threshold and/or timeout) into one registered,
// level-sensitive interrupt line. Software uses a single-cycle register port.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   events_i     [1:0] event levels from the SPI master (rising edge = event)
//   reg_req_i    register access strobe (one cycle)
//   reg_we_i     1 = write, 0 = read
//   reg_addr_i   [3:0] byte offset, bits [1:0] ignored
//   reg_wdata_i  [31:0] write data
//   reg_rdata_o  [31:0] read data, non-zero only while reg_ack_o is high
//   reg_ack_o    acknowledge, one cycle after reg_req_i
//   irq_o        coalesced interrupt, registered
//
// Register map:
//   0x0 STATUS [1:0] pending, write-1-to-clear (a same-cycle event wins)
//   0x4 MASK   [1:0] enable
//   0x8 COAL   [7:0] threshold (0 acts as 1), [8+TIMEOUT_WIDTH-1:8] timeout
//   0xC CNT    counter0 at [CNT_WIDTH-1:0], counter1 at [16+CNT_WIDTH-1:16];
//              any write clears both (a same-cycle event leaves a count of 1)
module spi_master_irq_ctrl #(
  parameter int CNT_WIDTH     = 16,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  events_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_ack_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRED = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               events_q;
  logic [1:0]               pending_q, pending_d;
  logic [1:0]               mask_q, mask_d;
  logic [7:0]               threshold_q, threshold_d;
  logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]     cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]     cnt1_q, cnt1_d;
  logic [7:0]               coal_cnt_q, coal_cnt_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic                     irq_q, irq_d;
  logic                     ack_q, ack_d;
  logic [31:0]              rdata_q, rdata_d;

  logic [1:0]  ev;
  logic        en_ev;
  logic        wr_stb;
  logic        rd_stb;
  logic [1:0]  sel;
  logic [7:0]  thr_eff;
  logic [7:0]  coal_inc;
  logic [31:0] rd_val;
  logic        unused_bits;

  // Address low bits are don't-care and only part of the write word is used.
  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

  always_comb begin
    ev       = events_i & ~events_q;
    en_ev    = |(ev & mask_q);
    wr_stb   = reg_req_i & reg_we_i;
    rd_stb   = reg_req_i & ~reg_we_i;
    sel      = reg_addr_i[3:2];
    thr_eff  = (threshold_q == 8'd0) ? 8'd1 : threshold_q;
    coal_inc = (coal_cnt_q == 8'hFF) ? coal_cnt_q : coal_cnt_q + 8'd1;

    // Set wins over a same-cycle W1C.
    pending_d = pending_q;
    if (wr_stb && sel == 2'd0) begin
      pending_d = pending_q & ~reg_wdata_i[1:0];
    end
    pending_d = pending_d | ev;

    mask_d      = mask_q;
    threshold_d = threshold_q;
    timeout_d   = timeout_q;
    if (wr_stb && sel == 2'd1) begin
      mask_d = reg_wdata_i[1:0];
    end
    if (wr_stb && sel == 2'd2) begin
      threshold_d = reg_wdata_i[7:0];
      timeout_d   = reg_wdata_i[8+TIMEOUT_WIDTH-1:8];
    end

    // Counter clear leaves room for an event landing in the same cycle.
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (wr_stb && sel == 2'd3) begin
      cnt0_d    = '0;
      cnt1_d    = '0;
      cnt0_d[0] = ev[0];
      cnt1_d[0] = ev[1];
    end else begin
      if (ev[0] && (cnt0_q != {CNT_WIDTH{1'b1}})) cnt0_d = cnt0_q + CNT_WIDTH'(1);
      if (ev[1] && (cnt1_q != {CNT_WIDTH{1'b1}})) cnt1_d = cnt1_q + CNT_WIDTH'(1);
    end

    // Coalescing. Losing every enabled pending bit (W1C or mask change)
    // drops back to idle from either active state; an enabled event in that
    // same cycle immediately starts a fresh coalescing window.
    state_d    = state_q;
    coal_cnt_d = coal_cnt_q;
    timer_d    = timer_q;
    if (state_q == IDLE || (pending_q & mask_q) == 2'b00) begin
      state_d    = IDLE;
      coal_cnt_d = 8'd0;
      timer_d    = '0;
      if (en_ev) begin
        coal_cnt_d = 8'd1;
        state_d    = (thr_eff <= 8'd1) ? FIRED : ACCUM;
      end
    end else if (state_q == ACCUM) begin
      if (en_ev) coal_cnt_d = coal_inc;
      if ((coal_cnt_d >= thr_eff) ||
          ((timeout_q != '0) && (timer_q == timeout_q - TIMEOUT_WIDTH'(1)))) begin
        state_d = FIRED;
      end else begin
        timer_d = timer_q + TIMEOUT_WIDTH'(1);
      end
    end else if (state_q == FIRED) begin
      // Further events are counted but never re-fire.
      if (en_ev) coal_cnt_d = coal_inc;
    end else begin
      state_d = IDLE;
    end
    irq_d = (state_d == FIRED);

    rd_val = '0;
    case (sel)
      2'd0: rd_val[1:0] = pending_q;
      2'd1: rd_val[1:0] = mask_q;
      2'd2: begin
        rd_val[7:0]                 = threshold_q;
        rd_val[8+TIMEOUT_WIDTH-1:8] = timeout_q;
      end
      default: begin
        rd_val[CNT_WIDTH-1:0]     = cnt0_q;
        rd_val[16+CNT_WIDTH-1:16] = cnt1_q;
      end
    endcase
    ack_d   = reg_req_i;
    rdata_d = rd_stb ? rd_val : 32'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      events_q    <= 2'b00;
      pending_q   <= 2'b00;
      mask_q      <= 2'b00;
      threshold_q <= 8'd1;
      timeout_q   <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      coal_cnt_q  <= 8'd0;
      timer_q     <= '0;
      irq_q       <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      events_q    <= events_i;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      threshold_q <= threshold_d;
      timeout_q   <= timeout_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      coal_cnt_q  <= coal_cnt_d;
      timer_q     <= timer_d;
      irq_q       <= irq_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  assign reg_rdata_o = rdata_q;
  assign reg_ack_o   = ack_q;
  assign irq_o       = irq_q;

endmodule

// File: doc/spi_master_irq_ctrl.md
Name: spi_master_irq_ctrl

Overview:
- Sits directly downstream of the SPI master's two-bit event output: bit0 is the TX-buffer level event, bit1 is end-of-transfer.
- Turns those event pulses into sticky pending flags and per-event saturating counters.
- Drives one coalesced, maskable interrupt line to the core's interrupt controller.
- Software reaches it through a simple single-cycle register port.

Parameters:
- CNT_WIDTH, 16: width of each per-event counter; legal range 1..16.
- TIMEOUT_WIDTH, 16: width of the coalescing timeout field and timer; legal range 1..16.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- events_i  in  2  event lines from the SPI master: bit0 TX level event, bit1 EOT. Treated as levels; rising edge is the event.
- reg_req_i  in  1  register access request; one-cycle strobe.
- reg_we_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  4  byte offset; bits [1:0] are ignored.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data; valid only while reg_ack_o is high, 0 otherwise.
- reg_ack_o  out  1  access acknowledge.
- irq_o  out  1  interrupt, level, registered.

Behaviour:
- Reset values: reg_rdata_o=0, reg_ack_o=0, irq_o=0, pending=0, mask=0, threshold=1, timeout=0, counters=0, coal_cnt=0, timer=0, state=IDLE.
- Edge detect: events_d is events_i registered. An event on bit n is events_i[n] & ~events_d[n].
- Pending[n] sets on an event regardless of mask; it is visible the cycle after the edge.
- Counter[n] increments on every event on bit n, regardless of mask, and saturates at all-ones.
- Register map (offset: contents):
  - 0x0 STATUS: [1:0] pending. Write-1-to-clear. If an event sets bit n in the same cycle a W1C clears it, set wins.
  - 0x4 MASK: [1:0] enable, read/write.
  - 0x8 COAL: [7:0] threshold, [8+TIMEOUT_WIDTH-1:8] timeout in cycles. A threshold of 0 behaves as 1. A timeout of 0 disables the timer.
  - 0xC CNT: [CNT_WIDTH-1:0] counter0, [16+CNT_WIDTH-1:16] counter1. Any write clears both counters; an event in the same cycle yields count 1.
  - 0x4..0xC unused bits read 0.
  - Unmapped offsets: ack is given, read returns 0, write is ignored.
- Register timing:
  - reg_ack_o pulses exactly 1 cycle after reg_req_i; rdata is presented in that same cycle.
  - Register writes take effect on the edge where reg_ack_o rises.
  - Back-to-back requests on consecutive cycles are accepted.
- Coalescing counter: coal_cnt (8 bit, saturating) increments by 1 in each cycle where (event & mask) is non-zero. Simultaneous enabled events on both bits still add 1.
- State machine:
  - IDLE: coal_cnt=0, timer=0, irq_o=0. An enabled event sets coal_cnt=1. If threshold<=1, go to FIRED; otherwise go to ACCUM.
  - ACCUM: timer increments each cycle.
    - Go to FIRED when coal_cnt reaches threshold.
    - Go to FIRED when timeout!=0 and timer==timeout-1.
    - If software clears all enabled pending bits, or mask becomes 0, return to IDLE and zero coal_cnt and timer.
  - FIRED: irq_o=1, registered, so it rises on the cycle state enters FIRED.
    - Stay while (pending & mask)!=0.
    - When (pending & mask)==0, return to IDLE; irq_o drops the next cycle and coal_cnt and timer are zeroed.
    - New enabled events in FIRED are counted toward coal_cnt but do not re-fire.
- Latency at threshold=1: enabled edge in cycle N gives pending and irq_o both high in cycle N+1.
- Masking: clearing a mask bit never clears pending. Setting a mask bit while that bit is already pending does not fire by itself; only a new enabled event starts coalescing.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; an event edge in flight is lost.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC -> 0, 0, 0x00000001, 0. irq_o=0. Each ack arrives 1 cycle after its req.
- MASK=0x2, COAL threshold=1; pulse events_i[1] at cycle N -> pending=0x2 and irq_o=1 at N+1. Write 0x0=0x2 -> irq_o=0 one cycle after the ack.
- MASK=0x3, threshold=3, timeout=0; three EOT pulses 5 cycles apart -> irq_o stays 0 after pulses 1 and 2 and rises 1 cycle after pulse 3.
- threshold=4, timeout=10; a single enabled event at cycle N -> irq_o rises at N+11. Write 0x0=0x3 -> back to IDLE; a new event restarts the timer from 0.
- Hold events_i[0] toggling for 70000 edges with CNT_WIDTH=16 -> counter0 reads 0xFFFF. Write 0xC -> both counters read 0. A W1C on bit 0 in the same cycle as an edge on bit 0 -> pending[0] stays 1.
- MASK=0; pulse both events -> pending=0x3, irq_o stays 0. Then write MASK=0x1 -> irq_o still 0 until the next edge on bit 0.
